// File: rtl/cut_bist_if.sv
// Control-side bundle between a test master and the BIST driver:
// start pulse in, status and result out.
interface cut_bist_if #(
  parameter int MISR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] signature;
  logic [15:0]       pat_count;

  modport master (output start, input busy, done, pass, signature, pat_count);
  modport slave  (input start, output busy, done, pass, signature, pat_count);
endinterface

// File: rtl/cut_bist.sv
// BIST wrapper: drives LFSR patterns into a benchmark CUT and compacts its
// responses into a MISR signature that is compared against a golden value.
module cut_bist_driver #(
  parameter int                N_IN      = 5,
  parameter int                N_OUT     = 2,
  parameter logic [N_IN-1:0]   TAPS      = 5'b10010,
  parameter logic [N_IN-1:0]   SEED      = 5'b00001,
  parameter int                PATTERNS  = 31,
  parameter int                MISR_W    = 8,
  parameter logic [MISR_W-1:0] MISR_POLY = 8'h1D,
  parameter logic [MISR_W-1:0] GOLDEN    = 8'h00,
  parameter int                CUT_LAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  cut_bist_if.slave        ctrl,
  output logic [N_IN-1:0]  cut_in_o,
  input  logic [N_OUT-1:0] cut_out_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

  localparam logic [15:0] LAST_PAT   = 16'(PATTERNS - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(CUT_LAT - 1);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     lfsr_q, lfsr_d;
  logic [MISR_W-1:0]   misr_q, misr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         drain_q, drain_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cap_s;

  function automatic logic [N_IN-1:0] lfsr_step(input logic [N_IN-1:0] l);
    return {l[N_IN-2:0], ^(l & TAPS)};
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [N_OUT-1:0] r);
    logic [MISR_W-1:0] ext;
    ext            = '0;
    ext[N_OUT-1:0] = r;
    return ({m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}})) ^ ext;
  endfunction

  // A pattern applied in RUN reaches the MISR CUT_LAT cycles later.
  if (CUT_LAT == 0) begin : g_comb_cut
    assign cap_s = (state_q == RUN);
  end else begin : g_pipe_cut
    logic [CUT_LAT-1:0] vpipe_q;

    // Capture-valid delay line matching the CUT latency
    always_ff @(posedge clk) begin
      if (rst) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q[0] <= (state_q == RUN);
        for (int i = 1; i < CUT_LAT; i++) begin
          vpipe_q[i] <= vpipe_q[i-1];
        end
      end
    end

    assign cap_s = vpipe_q[CUT_LAT-1];
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    pass_d  = pass_q;

    if (cap_s) begin
      misr_d = misr_step(misr_q, cut_out_i);
    end else begin
      misr_d = misr_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (ctrl.start) begin
          state_d = RUN;
          lfsr_d  = SEED;
          misr_d  = '0;
          cnt_d   = 16'd0;
          drain_d = 16'd0;
          pass_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LAST_PAT) begin
          // The final pattern stays on cut_in; no further LFSR advance.
          if (CUT_LAT == 0) begin
            state_d = DONE;
            pass_d  = (misr_d == GOLDEN);
          end else begin
            state_d = DRAIN;
          end
        end else begin
          lfsr_d = lfsr_step(lfsr_q);
        end
      end
      DRAIN: begin
        drain_d = drain_q + 16'd1;
        if (drain_q == LAST_DRAIN) begin
          state_d = DONE;
          pass_d  = (misr_d == GOLDEN);
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      misr_q  <= '0;
      cnt_q   <= 16'd0;
      drain_q <= 16'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cut_in_o       = lfsr_q;
  assign ctrl.busy      = busy_q;
  assign ctrl.done      = done_q;
  assign ctrl.pass      = pass_q;
  assign ctrl.signature = misr_q;
  assign ctrl.pat_count = cnt_q;

endmodule

// File: doc/cut_bist_driver.md
Name: cut_bist_driver

Overview:
- Built-in self-test wrapper that drives the stimulus end of a small combinational benchmark circuit under test (CUT), such as c17 with 5 inputs and 2 outputs, and compacts the CUT responses.
- Stimulus comes from an LFSR pattern generator. Responses are compacted into a MISR signature, which is compared against a golden value.
- Sits between a test-control master (start/done handshake) and the CUT netlist. Lets the same benchmark netlists be exercised in hardware.

Parameters:
- N_IN, 5, CUT input width and LFSR width.
- N_OUT, 2, CUT output width. Must be ≤ MISR_W.
- TAPS, 5'b10010, LFSR feedback mask (XOR of lfsr & TAPS).
- SEED, 5'b00001, LFSR value loaded on start. Must be nonzero.
- PATTERNS, 31, number of patterns applied per run (1..2^16-1).
- MISR_W, 8, signature width.
- MISR_POLY, 8'h1D, MISR feedback polynomial mask.
- GOLDEN, 8'h00, expected signature.
- CUT_LAT, 0, CUT response latency in cycles (0 = purely combinational CUT).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- cut_in  output  N_IN  pattern to CUT; bit order {G1,G2,G3,G6,G7} for c17 (MSB first).
- cut_out  input  N_OUT  CUT response; bit order {G22,G23}.
- busy  output  1  high from start acceptance until done.
- done  output  1  sticky; high in DONE until next accepted start or reset.
- pass  output  1  valid while done=1; 1 iff signature == GOLDEN.
- signature  output  MISR_W  current MISR contents.
- pat_count  output  16  patterns applied so far in current run.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - state=IDLE; cut_in=0, busy=0, done=0, pass=0, signature=0, pat_count=0.
  - Capture-valid pipe cleared.
  - Reset mid-run aborts immediately; no partial result is retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, or DONE, with start=1:
  - Next cycle: lfsr=SEED, cut_in=SEED, misr=0, pat_count=0, done=0, pass=0, busy=1, state=RUN.
- start while busy (RUN or DRAIN) is ignored.
- RUN, each cycle:
  - Current cut_in is applied and tagged valid into a CUT_LAT-deep valid pipe. With CUT_LAT=0 it is captured this same edge.
  - lfsr ← {lfsr[N_IN-2:0], ^(lfsr & TAPS)}; cut_in follows lfsr.
  - pat_count increments.
  - When pat_count reaches PATTERNS−1 on this edge (last pattern applied):
    - CUT_LAT=0 → DONE.
    - Otherwise → DRAIN.
  - cut_in holds its last value after the final pattern.
- DRAIN: waits exactly CUT_LAT cycles while remaining valid captures land, then → DONE.
- Capture: on each edge where the delayed valid is 1:
  - misr ← ({misr[MISR_W-2:0],1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : 0)) ^ zero-extend(cut_out).
  - Exactly PATTERNS captures occur per run.
- DONE:
  - busy=0, done=1, pass=(misr==GOLDEN) registered on entry.
  - signature and cut_in are held.
- Cycle count: start accepted at edge 0 → busy from cycle 1. DONE reached after PATTERNS+CUT_LAT further edges.
- PATTERNS=1: single pattern SEED, no LFSR advance observed at cut_in before DONE.
- Simultaneous rst and start: rst wins.

Test Plan:
- Combinational c17 (CUT_LAT=0), PATTERNS=1, SEED=5'b00001:
  - cut_in=00001 → cut_out=2'b01 → signature=8'h01.
  - done=1 after 1 run cycle; pass=1 with GOLDEN=8'h01, pass=0 with GOLDEN=8'h00.
- Same, PATTERNS=2:
  - cut_in sequence 00001, 00010; cut_out 01, 00 → signature=8'h02; pat_count=2.
- LFSR sequence check, PATTERNS=31:
  - cut_in steps 00001, 00010, 00101, 01010, 10101, 01011, …
  - All 31 nonzero values appear exactly once; the final signature matches the bench model.
- CUT_LAT=2 with a registered-CUT model, PATTERNS=4:
  - DRAIN lasts 2 cycles; exactly 4 captures.
  - Signature equals the CUT_LAT=0 run on the same patterns.
- start pulsed mid-RUN is ignored (pat_count continues).
- rst asserted mid-RUN → next cycle all outputs 0, state IDLE.
- Fresh start afterwards gives an identical signature to an uninterrupted run.
- Back-to-back runs: start in DONE clears done/pass next cycle, reloads SEED, and reproduces the same signature.
